// File: rtl/spike_aer_encoder_if.sv
// rtl/spike_aer_encoder_if.sv - sample input stream and AER event output bundle
//
// Purpose: groups the write-back sample stream (in_*) and the AER event
// valid/ready channel (aer_*) of spike_aer_encoder.
// Ports (signals):
//   in_valid, in_id, in_v          write-back sample from the TDM core
//   aer_valid, aer_id, aer_ts      head event offered to the consumer
//   aer_ready                      consumer accepts the head event
// Modports:
//   slave  - encoder side (consumes samples, produces events)
//   master - core/host side (produces samples, consumes events)
interface spike_aer_encoder_if #(
    parameter int ID_W       = 9,
    parameter int DATA_WIDTH = 16,
    parameter int TS_WIDTH   = 16
);
    logic                  in_valid;
    logic [ID_W-1:0]       in_id;
    logic [DATA_WIDTH-1:0] in_v;
    logic                  aer_valid;
    logic                  aer_ready;
    logic [ID_W-1:0]       aer_id;
    logic [TS_WIDTH-1:0]   aer_ts;

    modport slave (
        input  in_valid, in_id, in_v, aer_ready,
        output aer_valid, aer_id, aer_ts
    );

    modport master (
        output in_valid, in_id, in_v, aer_ready,
        input  aer_valid, aer_id, aer_ts
    );
endinterface

// File: rtl/spike_aer_encoder.sv
// rtl/spike_aer_encoder.sv - membrane write-back to AER spike event encoder
//
// Purpose: compares each time-multiplexed membrane sample against a signed
// Q4.12 threshold, fires on a rising crossing per neuron, and queues
// (id, sweep timestamp) events in a show-ahead FIFO drained by valid/ready.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   bus         spike_aer_encoder_if.slave: in_valid/in_id/in_v samples,
//               aer_valid/aer_ready/aer_id/aer_ts event channel
//   timestep    current sweep counter
//   overflow    sticky flag: at least one event was dropped
//   drop_count  number of dropped events, saturating at 16'hFFFF
module spike_aer_encoder #(
    parameter int NEURON_COUNT = 500,
    parameter int DATA_WIDTH   = 16,
    parameter int THRESHOLD    = 12288,
    parameter int FIFO_DEPTH   = 16,
    parameter int TS_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    spike_aer_encoder_if.slave     bus,
    output logic [TS_WIDTH-1:0]    timestep,
    output logic                   overflow,
    output logic [15:0]            drop_count
);
    localparam int ID_W = $clog2(NEURON_COUNT);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [ID_W-1:0]              LAST_ID  = ID_W'(NEURON_COUNT - 1);
    localparam logic signed [DATA_WIDTH-1:0] THRESH_V = DATA_WIDTH'(THRESHOLD);

    // ------------------------------------------------------------------
    // Input stage: accept, compare, rising-edge detect
    // ------------------------------------------------------------------
    logic [NEURON_COUNT-1:0] r_above;
    logic [TS_WIDTH-1:0]     r_timestep;

    logic w_accept;
    logic w_hit;
    logic w_spike;
    logic w_sweep_end;

    // Ids beyond the neuron range are ignored entirely, including for the
    // sweep counter, so a stray id cannot advance time.
    assign w_accept    = bus.in_valid && (bus.in_id <= LAST_ID);
    assign w_hit       = $signed(bus.in_v) >= THRESH_V;
    assign w_spike     = w_accept && w_hit && !r_above[bus.in_id];
    assign w_sweep_end = w_accept && (bus.in_id == LAST_ID);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_above <= '0;
        end else if (w_accept) begin
            r_above[bus.in_id] <= w_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timestep <= '0;
        end else if (w_sweep_end) begin
            r_timestep <= r_timestep + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: detect register. The timestamp is the pre-increment sweep
    // index, so the last neuron of a sweep is stamped with that sweep.
    // ------------------------------------------------------------------
    logic                r_spk_v;
    logic [ID_W-1:0]     r_spk_id;
    logic [TS_WIDTH-1:0] r_spk_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spk_v  <= 1'b0;
            r_spk_id <= '0;
            r_spk_ts <= '0;
        end else begin
            r_spk_v  <= w_spike;
            r_spk_id <= bus.in_id;
            r_spk_ts <= r_timestep;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: event FIFO (show-ahead). Pointers carry one extra bit so
    // full and empty are distinguishable when the indices match.
    // ------------------------------------------------------------------
    logic [ID_W-1:0]     r_mem_id [FIFO_DEPTH];
    logic [TS_WIDTH-1:0] r_mem_ts [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_pop    = !w_empty && bus.aer_ready;
    // A full FIFO still takes the event when the head leaves in the same
    // cycle; the write lands in the slot being vacated.
    assign w_push   = r_spk_v && (!w_full || w_pop);
    assign w_drop   = r_spk_v && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[w_wr_idx] <= r_spk_id;
            r_mem_ts[w_wr_idx] <= r_spk_ts;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting
    // ------------------------------------------------------------------
    logic        r_overflow;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Payload is forced to zero while empty so the memory (which
    // is never reset) cannot leak stale entries onto the bus.
    // ------------------------------------------------------------------
    assign bus.aer_valid = !w_empty;
    assign bus.aer_id    = w_empty ? '0 : r_mem_id[w_rd_idx];
    assign bus.aer_ts    = w_empty ? '0 : r_mem_ts[w_rd_idx];
    assign timestep      = r_timestep;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb/tb_spike_aer_encoder.sv - scoreboard testbench for spike_aer_encoder
module tb_spike_aer_encoder;
    localparam int NC = 500;
    localparam int DW = 16;
    localparam int TW = 16;
    localparam int IW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] timestep;
    logic          overflow;
    logic [15:0]   drop_count;

    spike_aer_encoder_if #(.ID_W(IW), .DATA_WIDTH(DW), .TS_WIDTH(TW)) bus ();

    spike_aer_encoder #(
        .NEURON_COUNT(NC),
        .DATA_WIDTH  (DW),
        .THRESHOLD   (12288),
        .FIFO_DEPTH  (16),
        .TS_WIDTH    (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .timestep  (timestep),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] ts;
    } ev_t;

    ev_t           exp_q[$];
    ev_t           mon_e;
    int            total = 0;
    int            bad   = 0;
    logic [TW-1:0] exp_ts = '0;

    // Scoreboard: every accepted event is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.aer_valid && bus.aer_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got id=%0d ts=%0d required no event", bus.aer_id, bus.aer_ts);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.aer_id !== mon_e.id || bus.aer_ts !== mon_e.ts) begin
                    bad++;
                    $display("FAIL event_payload got id=%0d ts=%0d required id=%0d ts=%0d",
                             bus.aer_id, bus.aer_ts, mon_e.id, mon_e.ts);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [IW-1:0] id, input logic [DW-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_v     = v;
        step(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic end_sweep();
        sample(IW'(NC - 1), '0);
        exp_ts++;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aer_ready = 1'b0;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        exp_ts = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.aer_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.aer_valid) && n < 300) begin
            step(1);
            n++;
        end
        step(3);
        total++;
        if (exp_q.size() != 0 || bus.aer_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain got pending=%0d aer_valid=%b required pending=0 aer_valid=0",
                     name, exp_q.size(), bus.aer_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        total += 6;
        if (bus.aer_valid !== 1'b0) begin bad++; $display("FAIL reset_aer_valid got %b required 0", bus.aer_valid); end
        if (bus.aer_id !== '0)      begin bad++; $display("FAIL reset_aer_id got %0d required 0", bus.aer_id); end
        if (bus.aer_ts !== '0)      begin bad++; $display("FAIL reset_aer_ts got %0d required 0", bus.aer_ts); end
        if (timestep !== '0)        begin bad++; $display("FAIL reset_timestep got %0d required 0", timestep); end
        if (overflow !== 1'b0)      begin bad++; $display("FAIL reset_overflow got %b required 0", overflow); end
        if (drop_count !== 16'd0)   begin bad++; $display("FAIL reset_drop_count got %0d required 0", drop_count); end
    endtask

    task automatic test_single_crossing();
        do_reset();
        bus.aer_ready = 1'b1;
        sample(IW'(0), 16'd0);
        end_sweep();
        exp_q.push_back({IW'(0), TW'(1)});
        sample(IW'(0), 16'h4000);
        total++;
        if (bus.aer_valid !== 1'b0) begin bad++; $display("FAIL latency_early got aer_valid=%b required 0", bus.aer_valid); end
        step(1);
        total++;
        if (bus.aer_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got aer_valid=%b required 1", bus.aer_valid); end
        wait_drain("single");
    endtask

    task automatic test_sustained();
        do_reset();
        bus.aer_ready = 1'b1;
        exp_q.push_back({IW'(150), TW'(0)});
        for (int s = 0; s < 5; s++) begin
            sample(IW'(150), 16'h4000);
            end_sweep();
        end
        sample(IW'(150), 16'hF000);
        end_sweep();
        exp_q.push_back({IW'(150), TW'(6)});
        sample(IW'(150), 16'h4000);
        end_sweep();
        total++;
        if (timestep !== TW'(7)) begin bad++; $display("FAIL sustained_timestep got %0d required 7", timestep); end
        wait_drain("sustained");
    endtask

    task automatic test_threshold_edges();
        do_reset();
        bus.aer_ready = 1'b1;
        exp_q.push_back({IW'(10), TW'(0)});
        sample(IW'(10), 16'd12288);
        sample(IW'(11), 16'd12287);
        sample(IW'(12), 16'h8000);
        sample(IW'(500), 16'h4000);
        step(2);
        total++;
        if (timestep !== TW'(0)) begin bad++; $display("FAIL out_of_range_timestep got %0d required 0", timestep); end
        exp_q.push_back({IW'(499), TW'(0)});
        sample(IW'(499), 16'h4000);
        total++;
        if (timestep !== TW'(1)) begin bad++; $display("FAIL last_id_timestep got %0d required 1", timestep); end
        wait_drain("threshold");
    endtask

    task automatic test_overflow_and_full_pushpop();
        do_reset();
        bus.aer_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back({IW'(20 + i), TW'(0)});
            sample(IW'(20 + i), 16'h4000);
        end
        step(2);
        total += 3;
        if (overflow !== 1'b1)     begin bad++; $display("FAIL overflow_flag got %b required 1", overflow); end
        if (drop_count !== 16'd4)  begin bad++; $display("FAIL overflow_drop_count got %0d required 4", drop_count); end
        if (bus.aer_valid !== 1'b1) begin bad++; $display("FAIL overflow_valid got %b required 1", bus.aer_valid); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.aer_id !== exp_q[0].id || bus.aer_ts !== exp_q[0].ts) begin
                bad++;
                $display("FAIL stall_stable got id=%0d ts=%0d required id=%0d ts=%0d",
                         bus.aer_id, bus.aer_ts, exp_q[0].id, exp_q[0].ts);
            end
            step(1);
        end
        // FIFO full; the new spike reaches stage 2 in the cycle the head pops.
        exp_q.push_back({IW'(40), TW'(0)});
        sample(IW'(40), 16'h4000);
        bus.aer_ready = 1'b1;
        step(1);
        bus.aer_ready = 1'b0;
        step(2);
        total += 2;
        if (drop_count !== 16'd4) begin bad++; $display("FAIL pushpop_drop_count got %0d required 4", drop_count); end
        if (overflow !== 1'b1)    begin bad++; $display("FAIL pushpop_overflow got %b required 1", overflow); end
        wait_drain("overflow");
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        bus.aer_ready = 1'b1;
        for (int s = 0; s < 65537; s++) end_sweep();
        total++;
        if (timestep !== TW'(1)) begin bad++; $display("FAIL wrap_timestep got %0d required 1", timestep); end
        exp_q.push_back({IW'(7), TW'(1)});
        sample(IW'(7), 16'h4000);
        wait_drain("wrap");

        bus.aer_ready = 1'b0;
        sample(IW'(1), 16'h4000);
        sample(IW'(2), 16'h4000);
        sample(IW'(3), 16'h4000);
        step(1);
        total++;
        if (bus.aer_valid !== 1'b1) begin bad++; $display("FAIL prereset_valid got %b required 1", bus.aer_valid); end
        sample(IW'(5), 16'h4000);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        total += 6;
        if (bus.aer_valid !== 1'b0) begin bad++; $display("FAIL midreset_aer_valid got %b required 0", bus.aer_valid); end
        if (bus.aer_id !== '0)      begin bad++; $display("FAIL midreset_aer_id got %0d required 0", bus.aer_id); end
        if (bus.aer_ts !== '0)      begin bad++; $display("FAIL midreset_aer_ts got %0d required 0", bus.aer_ts); end
        if (timestep !== '0)        begin bad++; $display("FAIL midreset_timestep got %0d required 0", timestep); end
        if (overflow !== 1'b0)      begin bad++; $display("FAIL midreset_overflow got %b required 0", overflow); end
        if (drop_count !== 16'd0)   begin bad++; $display("FAIL midreset_drop_count got %0d required 0", drop_count); end
        step(2);
        total++;
        if (bus.aer_valid !== 1'b0) begin bad++; $display("FAIL inflight_discard got aer_valid=%b required 0", bus.aer_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_id     = '0;
        bus.in_v      = '0;
        bus.aer_ready = 1'b0;
        test_reset();
        test_single_crossing();
        test_sustained();
        test_threshold_edges();
        test_overflow_and_full_pushpop();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
